wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (WB stage) and the result stream of long-latency units such as the divider and the uncached-load return. The block buffers long-latency results in a small FIFO and grants the port each cycle. A starvation counter forces a drain phase that stalls WB. It sits between the WB stage / long-latency units and the regfile write port and debug trace outputs. It also exports a pending-destination bitmap that the ID stage uses for interlock.

Parameters:
FIFO_DEPTH, 4, number of buffered long-latency results (power of two, >=2)
STARVE_MAX, 8, consecutive denied cycles with a non-empty FIFO before a forced drain
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ws_valid  in  1  WB stage holds a valid instruction
ws_we  in  1  WB instruction writes the regfile
ws_dest  in  5  WB destination register
ws_pc  in  32  WB instruction PC
ws_result  in  32  WB write data
ws_stall  out  1  WB must hold its current instruction (feeds WB allow-in)
lu_valid  in  1  long-latency unit presents a result
lu_dest  in  5  its destination
lu_pc  in  32  its PC
lu_result  in  32  its data
lu_ready  out  1  FIFO accepts the result this cycle
rf_we  out  1  regfile write enable (registered)
rf_waddr  out  5  regfile write address (registered)
rf_wdata  out  32  regfile write data (registered)
debug_wb_pc  out  32  PC of the retired write (registered)
debug_wb_rf_we  out  4  {4{rf_we}}
lu_pending  out  32  bit r = some FIFO entry targets register r
fifo_count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (rst==0 at a clk edge):
  - FIFO is flushed and in-flight entries are discarded.
  - State goes to NORMAL and the starve counter to 0.
  - rf_we, rf_waddr, rf_wdata, debug_wb_pc and fifo_count go to 0. lu_pending goes to 0.
  - While rst is low, lu_ready=0 and ws_stall=0.
- Push: on lu_valid && lu_ready, the tuple {dest, pc, result} is pushed.
  - A tuple with lu_dest==0 is acknowledged but not stored.
  - lu_ready = (fifo_count < FIFO_DEPTH) && state==NORMAL.
  - No pop-through: lu_ready stays 0 while full, even if a pop happens in the same cycle.
- WB request: ws_req = ws_valid && ws_we && ws_dest!=0.
- Grant in NORMAL (combinational):
  - If ws_req, grant WS.
  - Else if the FIFO is non-empty, grant LU (pop head).
  - Else grant none.
  - ws_valid with no write (ws_we==0 or dest 0) leaves the port to LU.
- Grant in DRAIN: grant LU whenever the FIFO is non-empty. ws_stall=1 for the whole DRAIN state. ws_stall=0 in NORMAL.
- An empty FIFO plus a push in the same cycle gives no bypass. The entry is grantable the next cycle.
- Output latency: one cycle. At the edge after a grant, rf_we=1 and rf_waddr/rf_wdata/debug_wb_pc take the granted source. With no grant, rf_we=0 and the other outputs hold.
- Starve counter:
  - In NORMAL, it increments when the FIFO is non-empty and LU is not granted.
  - It clears on an LU grant or when the FIFO is empty.
  - It saturates at STARVE_MAX.
- State transitions:
  - NORMAL->DRAIN at the edge where the counter equals STARVE_MAX.
  - DRAIN->NORMAL at the edge where the pop empties the FIFO; the counter clears.
  - DRAIN always terminates, because lu_ready=0 in DRAIN.
- lu_pending is the OR of the one-hot decoded dests of all valid entries, computed from the registered contents. Duplicate dests stay set until the last matching entry pops.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is updated with +1/-1/0 for push-only, pop-only and both-or-neither.

Test Plan:
- Reset: rst=0 for 2 cycles with lu_valid=1 -> lu_ready=0, rf_we=0, fifo_count=0, lu_pending=0. After release, lu_ready=1.
- Priority: FIFO holds {r5, 0xAAAA}; ws_req to r3 with 0x1234 -> next cycle rf_waddr=3, rf_wdata=0x1234. Then with ws_we=0 -> rf_waddr=5, rf_wdata=0xAAAA, and lu_pending[5] clears.
- Starvation: FIFO holds 1 entry and ws_req is held continuously -> after 8 denied cycles ws_stall=1. The entry retires and ws_stall drops the cycle after the FIFO empties. The stalled WB instruction then writes.
- Full FIFO: push 4 entries with ws_req held -> fifo_count=4, lu_ready=0. lu_ready returns after the first pop.
- Dest 0 / duplicates: push r0 -> acknowledged, fifo_count unchanged. Push r7 twice -> lu_pending[7] stays set until the second pop.
- Mid-operation reset: 3 entries queued in DRAIN, then rst=0 -> FIFO empty, state NORMAL, no rf_we pulse after release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the signals around the register-file write port arbiter:
//   - WB stage request: ws_valid/ws_we/ws_dest/ws_pc/ws_result, and ws_stall back.
//   - Long-latency result stream: lu_valid/lu_dest/lu_pc/lu_result, and lu_ready back.
//   - Registered regfile write port: rf_we/rf_waddr/rf_wdata.
//   - Debug trace outputs: debug_wb_pc/debug_wb_rf_we.
//   - Status outputs: lu_pending (ID interlock bitmap) and fifo_count.
//   The slave modport is taken by the arbiter; the master modport is the
//   pipeline / environment side.
interface wb_port_arbiter_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  logic             ws_valid;
  logic             ws_we;
  logic [4:0]       ws_dest;
  logic [31:0]      ws_pc;
  logic [31:0]      ws_result;
  logic             ws_stall;
  logic             lu_valid;
  logic [4:0]       lu_dest;
  logic [31:0]      lu_pc;
  logic [31:0]      lu_result;
  logic             lu_ready;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_we;
  logic [31:0]      lu_pending;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  ws_valid, ws_we, ws_dest, ws_pc, ws_result,
    input  lu_valid, lu_dest, lu_pc, lu_result,
    output ws_stall, lu_ready,
    output rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we,
    output lu_pending, fifo_count
  );

  modport master (
    output ws_valid, ws_we, ws_dest, ws_pc, ws_result,
    output lu_valid, lu_dest, lu_pc, lu_result,
    input  ws_stall, lu_ready,
    input  rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we,
    input  lu_pending, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single regfile write port between the WB stage and buffered
//   long-latency results. WB has priority in NORMAL; a starvation counter
//   forces a DRAIN phase that stalls WB until the result FIFO is empty.
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-low reset
//     bus  - wb_port_arbiter_if.slave (WB request, LU stream, regfile port,
//            debug trace, lu_pending bitmap, fifo_count)
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_port_arbiter_if.slave      bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [SC_W-1:0]       starve_cnt, starve_nxt;

  logic [4:0]            dest_mem [FIFO_DEPTH];
  logic [31:0]           pc_mem   [FIFO_DEPTH];
  logic [31:0]           res_mem  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  ws_req, fifo_empty;
  logic                  grant_ws, grant_lu, push, pop;
  logic                  lu_ready, ws_stall;
  logic [31:0]           pending;

  logic                  vld_p1;
  logic [4:0]            waddr_p1;
  logic [31:0]           wdata_p1, pc_p1;

  assign ws_req     = bus.ws_valid && bus.ws_we && (bus.ws_dest != 5'd0);
  assign fifo_empty = (count == '0);
  // Dest-0 results are acknowledged through lu_ready but never stored.
  assign push       = bus.lu_valid && lu_ready && (bus.lu_dest != 5'd0);
  assign pop        = grant_lu;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    starve_nxt = starve_cnt;
    state_nxt  = state;
    if (grant_lu || fifo_empty)
      starve_nxt = '0;
    else if (state == NORMAL && starve_cnt < SC_W'(STARVE_MAX))
      starve_nxt = starve_cnt + 1'b1;
    case (state)
      NORMAL: if (starve_nxt == SC_W'(STARVE_MAX)) state_nxt = DRAIN;
      // No pushes are accepted in DRAIN, so the FIFO always empties.
      DRAIN:  if (fifo_empty || (pop && count == CNT_W'(1))) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // Output / grant logic; handshakes are held off while reset is asserted.
  always_comb begin
    grant_ws = 1'b0;
    grant_lu = 1'b0;
    lu_ready = 1'b0;
    ws_stall = 1'b0;
    case (state)
      NORMAL: begin
        // No pop-through: a full FIFO refuses even when popping this cycle.
        lu_ready = rst && (count < CNT_W'(FIFO_DEPTH));
        if (ws_req)           grant_ws = 1'b1;
        else if (!fifo_empty) grant_lu = 1'b1;
      end
      DRAIN: begin
        ws_stall = rst;
        grant_lu = !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= bus.lu_dest;
      pc_mem[wr_ptr]   <= bus.lu_pc;
      res_mem[wr_ptr]  <= bus.lu_result;
    end
  end

  // Duplicate dests keep their bit set until the last matching entry pops.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) pending[dest_mem[i]] = 1'b1;
  end

  // p1: registered regfile write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      pc_p1    <= '0;
    end else if (grant_ws) begin
      vld_p1   <= 1'b1;
      waddr_p1 <= bus.ws_dest;
      wdata_p1 <= bus.ws_result;
      pc_p1    <= bus.ws_pc;
    end else if (grant_lu) begin
      vld_p1   <= 1'b1;
      waddr_p1 <= dest_mem[rd_ptr];
      wdata_p1 <= res_mem[rd_ptr];
      pc_p1    <= pc_mem[rd_ptr];
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.ws_stall       = ws_stall;
  assign bus.lu_ready       = lu_ready;
  assign bus.rf_we          = vld_p1;
  assign bus.rf_waddr       = waddr_p1;
  assign bus.rf_wdata       = wdata_p1;
  assign bus.debug_wb_pc    = pc_p1;
  assign bus.debug_wb_rf_we = {4{vld_p1}};
  assign bus.lu_pending     = pending;
  assign bus.fifo_count     = count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed, self-checking bench for wb_port_arbiter. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ws_valid = 0; bus.ws_we = 0; bus.ws_dest = 0; bus.ws_pc = 0; bus.ws_result = 0;
    bus.lu_valid = 0; bus.lu_dest = 0; bus.lu_pc = 0; bus.lu_result = 0;
  endtask

  task automatic set_ws(input logic [4:0] d, input logic [31:0] pc, input logic [31:0] r);
    bus.ws_valid = 1; bus.ws_we = 1; bus.ws_dest = d; bus.ws_pc = pc; bus.ws_result = r;
  endtask

  task automatic set_lu(input logic [4:0] d, input logic [31:0] pc, input logic [31:0] r);
    bus.lu_valid = 1; bus.lu_dest = d; bus.lu_pc = pc; bus.lu_result = r;
  endtask

  task automatic test_reset();
    rst = 0;
    set_lu(5'd9, 32'h90, 32'h9999);
    step(); step();
    n_tests++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready got %0b exp 0", bus.lu_ready); end
    n_tests++; if (bus.ws_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ws_stall got %0b exp 0", bus.ws_stall); end
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b exp 0", bus.rf_we); end
    n_tests++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got %0d exp 0", bus.rf_waddr); end
    n_tests++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
    n_tests++; if (bus.lu_pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", bus.lu_pending); end
    idle();
    rst = 1;
    #1;
    n_tests++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0b exp 1", bus.lu_ready); end
  endtask

  task automatic test_priority();
    set_lu(5'd5, 32'h100, 32'hAAAA);
    step();
    idle();
    n_tests++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL prio_count got %0d exp 1", bus.fifo_count); end
    n_tests++; if (bus.lu_pending !== 32'h20) begin n_fail++; $display("FAIL prio_pending got %h exp 20", bus.lu_pending); end
    set_ws(5'd3, 32'h200, 32'h1234);
    step();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h1234 || bus.debug_wb_pc !== 32'h200)
      begin n_fail++; $display("FAIL prio_ws_write got we=%0b a=%0d d=%h pc=%h exp 1/3/1234/200", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc); end
    n_tests++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL prio_count_held got %0d exp 1", bus.fifo_count); end
    bus.ws_we = 0;
    step();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAAAA || bus.debug_wb_pc !== 32'h100)
      begin n_fail++; $display("FAIL prio_lu_write got we=%0b a=%0d d=%h pc=%h exp 1/5/aaaa/100", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc); end
    n_tests++; if (bus.debug_wb_rf_we !== 4'hF) begin n_fail++; $display("FAIL prio_dbg_we got %h exp f", bus.debug_wb_rf_we); end
    n_tests++; if (bus.lu_pending !== 32'h0 || bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL prio_pop got pend=%h cnt=%0d exp 0/0", bus.lu_pending, bus.fifo_count); end
    idle();
    step();
    n_tests++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAAAA)
      begin n_fail++; $display("FAIL prio_idle_hold got we=%0b a=%0d d=%h exp 0/5/aaaa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_starvation();
    set_lu(5'd6, 32'h300, 32'hBEEF);
    step();
    idle();
    set_ws(5'd4, 32'h400, 32'h4444);
    repeat (7) step();
    n_tests++; if (bus.ws_stall !== 1'b0 || bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL starve_7 got stall=%0b cnt=%0d exp 0/1", bus.ws_stall, bus.fifo_count); end
    step();
    n_tests++; if (bus.ws_stall !== 1'b1) begin n_fail++; $display("FAIL starve_8_stall got %0b exp 1", bus.ws_stall); end
    n_tests++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_drain_ready got %0b exp 0", bus.lu_ready); end
    n_tests++; if (bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h4444) begin n_fail++; $display("FAIL starve_last_ws got a=%0d d=%h exp 4/4444", bus.rf_waddr, bus.rf_wdata); end
    step();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'hBEEF || bus.debug_wb_pc !== 32'h300)
      begin n_fail++; $display("FAIL starve_drain_write got we=%0b a=%0d d=%h pc=%h exp 1/6/beef/300", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc); end
    n_tests++; if (bus.ws_stall !== 1'b0 || bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL starve_exit got stall=%0b cnt=%0d exp 0/0", bus.ws_stall, bus.fifo_count); end
    step();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h4444)
      begin n_fail++; $display("FAIL starve_ws_resume got we=%0b a=%0d d=%h exp 1/4/4444", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    idle();
    step();
  endtask

  task automatic test_full();
    set_ws(5'd8, 32'h800, 32'h8888);
    for (int i = 1; i <= 4; i++) begin
      set_lu(5'(i), 32'h1000 + 32'(i), 32'h11 * 32'(i));
      step();
    end
    set_lu(5'd9, 32'h1009, 32'h99);
    n_tests++; if (bus.fifo_count !== 3'd4 || bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%0b exp 4/0", bus.fifo_count, bus.lu_ready); end
    n_tests++; if (bus.lu_pending !== 32'h1E) begin n_fail++; $display("FAIL full_pending got %h exp 1e", bus.lu_pending); end
    step();
    n_tests++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_refuse got cnt=%0d exp 4", bus.fifo_count); end
    bus.ws_we = 0;
    bus.lu_valid = 0;
    #1;
    n_tests++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_popthrough got %0b exp 0", bus.lu_ready); end
    step();
    n_tests++; if (bus.fifo_count !== 3'd3 || bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_first_pop got cnt=%0d rdy=%0b exp 3/1", bus.fifo_count, bus.lu_ready); end
    n_tests++; if (bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'h11) begin n_fail++; $display("FAIL full_head got a=%0d d=%h exp 1/11", bus.rf_waddr, bus.rf_wdata); end
    repeat (3) step();
    n_tests++; if (bus.fifo_count !== 3'd0 || bus.lu_pending !== 32'h0) begin n_fail++; $display("FAIL full_drained got cnt=%0d pend=%h exp 0/0", bus.fifo_count, bus.lu_pending); end
    n_tests++; if (bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h44 || bus.debug_wb_pc !== 32'h1004)
      begin n_fail++; $display("FAIL full_tail got a=%0d d=%h pc=%h exp 4/44/1004", bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc); end
    idle();
    step();
  endtask

  task automatic test_dest0_dup();
    set_lu(5'd0, 32'h500, 32'hDEAD);
    #1;
    n_tests++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL d0_ack got %0b exp 1", bus.lu_ready); end
    step();
    idle();
    n_tests++; if (bus.fifo_count !== 3'd0 || bus.lu_pending !== 32'h0) begin n_fail++; $display("FAIL d0_not_stored got cnt=%0d pend=%h exp 0/0", bus.fifo_count, bus.lu_pending); end
    step();
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL d0_no_write got %0b exp 0", bus.rf_we); end
    set_ws(5'd2, 32'h600, 32'h2222);
    set_lu(5'd7, 32'h700, 32'h71);
    step();
    set_lu(5'd7, 32'h704, 32'h72);
    step();
    bus.lu_valid = 0;
    n_tests++; if (bus.fifo_count !== 3'd2 || bus.lu_pending !== 32'h80) begin n_fail++; $display("FAIL dup_queued got cnt=%0d pend=%h exp 2/80", bus.fifo_count, bus.lu_pending); end
    bus.ws_valid = 0;
    step();
    n_tests++; if (bus.lu_pending !== 32'h80 || bus.fifo_count !== 3'd1 || bus.rf_wdata !== 32'h71)
      begin n_fail++; $display("FAIL dup_first_pop got pend=%h cnt=%0d d=%h exp 80/1/71", bus.lu_pending, bus.fifo_count, bus.rf_wdata); end
    step();
    n_tests++; if (bus.lu_pending !== 32'h0 || bus.rf_wdata !== 32'h72 || bus.rf_waddr !== 5'd7)
      begin n_fail++; $display("FAIL dup_second_pop got pend=%h d=%h a=%0d exp 0/72/7", bus.lu_pending, bus.rf_wdata, bus.rf_waddr); end
    idle();
    step();
  endtask

  task automatic test_mid_reset();
    set_ws(5'd1, 32'hA00, 32'hA1A1);
    for (int i = 0; i < 3; i++) begin
      set_lu(5'(10 + i), 32'hB00 + 32'(i), 32'hC0 + 32'(i));
      step();
    end
    bus.lu_valid = 0;
    repeat (6) step();
    n_tests++; if (bus.ws_stall !== 1'b1 || bus.fifo_count !== 3'd3 || bus.lu_pending !== 32'h1C00)
      begin n_fail++; $display("FAIL mid_drain got stall=%0b cnt=%0d pend=%h exp 1/3/1c00", bus.ws_stall, bus.fifo_count, bus.lu_pending); end
    idle();
    rst = 0;
    #1;
    n_tests++; if (bus.ws_stall !== 1'b0 || bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_comb got stall=%0b rdy=%0b exp 0/0", bus.ws_stall, bus.lu_ready); end
    step();
    n_tests++; if (bus.fifo_count !== 3'd0 || bus.lu_pending !== 32'h0 || bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0)
      begin n_fail++; $display("FAIL mid_rst_flush got cnt=%0d pend=%h we=%0b a=%0d exp 0/0/0/0", bus.fifo_count, bus.lu_pending, bus.rf_we, bus.rf_waddr); end
    rst = 1;
    #1;
    n_tests++; if (bus.ws_stall !== 1'b0 || bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release got stall=%0b rdy=%0b exp 0/1", bus.ws_stall, bus.lu_ready); end
    step();
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse1 got %0b exp 0", bus.rf_we); end
    step();
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse2 got %0b exp 0", bus.rf_we); end
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_priority();
    test_starvation();
    test_full();
    test_dest0_dup();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
